// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and counter sizing.
// Optional rotate support is enabled by defining USR_ROTATE_EN.
package usr_pkg;

    typedef enum logic [1:0] {
        HOLD        = 2'd0,
        SHIFT_LEFT  = 2'd1,
        SHIFT_RIGHT = 2'd2,
        LOAD        = 2'd3
    } usr_mode_e;

    // Counter must hold 0..DEPTH even though it wraps before reaching DEPTH.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/usr_if.sv
// Control/data bundle for universal_shift_register; rotate exists only with USR_ROTATE_EN.
// word_valid is a one-cycle pulse with no ready: the consumer must take it the cycle it is high.
interface usr_if #(
    parameter int LANES = 1,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   en;
    logic [1:0]             mode;
    logic [LANES-1:0]       in;
    logic [LANES*DEPTH-1:0] load_data;
    logic [LANES*DEPTH-1:0] out;
    logic [LANES-1:0]       serial_out;
    logic                   word_valid;
    logic [CW-1:0]          shift_count;
`ifdef USR_ROTATE_EN
    logic                   rotate;
`endif

    modport master (
`ifdef USR_ROTATE_EN
        output rotate,
`endif
        output en, mode, in, load_data,
        input  out, serial_out, word_valid, shift_count
    );

    modport slave (
`ifdef USR_ROTATE_EN
        input  rotate,
`endif
        input  en, mode, in, load_data,
        output out, serial_out, word_valid, shift_count
    );

endinterface

// File: rtl/usr_lane.sv
// One DEPTH-bit lane: left/right shift, parallel load, and the bit leaving on the current shift.
module usr_lane
    import usr_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  usr_mode_e        mode,
    input  logic             sin,
    input  logic             rotate,
    input  logic [DEPTH-1:0] load_val,
    output logic [DEPTH-1:0] q,
    output logic             sout
);

    logic fill;

    always_comb begin
        sout = 1'b0;
        case (mode)
            SHIFT_LEFT:  sout = q[DEPTH-1];
            SHIFT_RIGHT: sout = q[0];
            default:     sout = 1'b0;
        endcase
    end

    // Rotation feeds the outgoing bit back into the opposite end.
    assign fill = rotate ? sout : sin;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            case (mode)
                SHIFT_LEFT:  q <= {q[DEPTH-2:0], fill};
                SHIFT_RIGHT: q <= {fill, q[DEPTH-1:1]};
                LOAD:        q <= load_val;
                default:     q <= q;
            endcase
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Multi-lane universal shift register with a shared word counter and word_valid pulse.
// Define USR_ROTATE_EN to add the rotate input.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int LANES = 1,
    parameter int DEPTH = 8
) (
    input logic  clk,
    input logic  reset,
    usr_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    usr_mode_e              mode;
    logic                   rotate;
    logic                   shifting;
    logic [LANES*DEPTH-1:0] q_all;
    logic [LANES-1:0]       sout_all;
    logic [CW-1:0]          cnt;
    logic                   wv;

    assign mode = usr_mode_e'(bus.mode);

`ifdef USR_ROTATE_EN
    assign rotate = bus.rotate;
`else
    assign rotate = 1'b0;
`endif

    assign shifting = bus.en && (mode == SHIFT_LEFT || mode == SHIFT_RIGHT);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        usr_lane #(.DEPTH(DEPTH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en       (bus.en),
            .mode     (mode),
            .sin      (bus.in[k]),
            .rotate   (rotate),
            .load_val (bus.load_data[k*DEPTH +: DEPTH]),
            .q        (q_all[k*DEPTH +: DEPTH]),
            .sout     (sout_all[k])
        );
    end

    // Direction changes do not disturb the count; only LOAD and reset clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            wv  <= 1'b0;
        end else begin
            wv <= 1'b0;
            if (shifting) begin
                if (cnt == LAST) begin
                    cnt <= '0;
                    wv  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (bus.en && mode == LOAD) begin
                cnt <= '0;
            end
        end
    end

    assign bus.out         = q_all;
    assign bus.serial_out  = sout_all;
    assign bus.word_valid  = wv;
    assign bus.shift_count = cnt;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: a 1x8 instance and a 2x4 instance on one clock.
module tb_universal_shift_register;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    usr_if #(.LANES(1), .DEPTH(8)) ifa ();
    usr_if #(.LANES(2), .DEPTH(4)) ifb ();

    universal_shift_register #(.LANES(1), .DEPTH(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    universal_shift_register #(.LANES(2), .DEPTH(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp8;
        errors = 0;
        checks = 0;

        reset = 1'b1;
        ifa.en = 1'b0; ifa.mode = 2'd0; ifa.in = '0; ifa.load_data = '0;
        ifb.en = 1'b0; ifb.mode = 2'd0; ifb.in = '0; ifb.load_data = '0;
`ifdef USR_ROTATE_EN
        ifa.rotate = 1'b0;
        ifb.rotate = 1'b0;
`endif
        step();
        reset = 1'b0;
        check("rst_out", 32'(ifa.out), 32'h0);
        check("rst_cnt", 32'(ifa.shift_count), 32'h0);
        check("rst_wv", 32'(ifa.word_valid), 32'h0);
        check("rst_sout", 32'(ifa.serial_out), 32'h0);

        // Walking one through a full 8-bit word.
        ifa.en = 1'b1; ifa.mode = 2'd1; ifa.in = 1'b1;
        step();
        check("sl_out_1", 32'(ifa.out), 32'h01);
        check("sl_cnt_1", 32'(ifa.shift_count), 32'd1);
        ifa.in = 1'b0;
        for (int i = 1; i < 8; i++) begin
            check("sl_wv_low", 32'(ifa.word_valid), 32'h0);
            step();
            exp8 = 8'h01 << i;
            check("sl_out", 32'(ifa.out), 32'(exp8));
        end
        check("sl_wv_pulse", 32'(ifa.word_valid), 32'h1);
        check("sl_cnt_wrap", 32'(ifa.shift_count), 32'h0);
        ifa.en = 1'b0; ifa.mode = 2'd0;
        step();
        check("sl_wv_drop", 32'(ifa.word_valid), 32'h0);
        check("sl_hold_out", 32'(ifa.out), 32'h80);

        // Load then shift right, watching the outgoing bits.
        ifa.en = 1'b1; ifa.mode = 2'd3; ifa.load_data = 8'hA5;
        step();
        check("ld_out", 32'(ifa.out), 32'hA5);
        check("ld_cnt", 32'(ifa.shift_count), 32'h0);
        ifa.mode = 2'd2; ifa.in = 1'b0;
        #1;
        check("sr_sout0", 32'(ifa.serial_out), 32'h1);
        step();
        check("sr_sout1", 32'(ifa.serial_out), 32'h0);
        step();
        check("sr_sout2", 32'(ifa.serial_out), 32'h1);
        step();
        check("sr_sout3", 32'(ifa.serial_out), 32'h0);
        step();
        check("sr_out", 32'(ifa.out), 32'h0A);
        check("sr_cnt", 32'(ifa.shift_count), 32'd4);

        // Fifth shift, enable-low hold, then reset overriding a load.
        ifa.mode = 2'd1;
        step();
        check("s5_out", 32'(ifa.out), 32'h14);
        check("s5_cnt", 32'(ifa.shift_count), 32'd5);
        ifa.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_out", 32'(ifa.out), 32'h14);
            check("hold_cnt", 32'(ifa.shift_count), 32'd5);
            check("hold_wv", 32'(ifa.word_valid), 32'h0);
        end
        ifa.en = 1'b1; ifa.mode = 2'd3; ifa.load_data = 8'hFF; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_out", 32'(ifa.out), 32'h0);
        check("rst2_cnt", 32'(ifa.shift_count), 32'h0);
        check("rst2_wv", 32'(ifa.word_valid), 32'h0);

        // First shift after reset counts as one; direction change keeps counting.
        ifa.mode = 2'd1; ifa.in = 1'b1;
        step();
        check("first_cnt", 32'(ifa.shift_count), 32'd1);
        check("first_out", 32'(ifa.out), 32'h01);
        ifa.in = 1'b0;
        step();
        step();
        check("dir_out_l", 32'(ifa.out), 32'h04);
        ifa.mode = 2'd2;
        for (int i = 0; i < 4; i++) step();
        check("dir_cnt7", 32'(ifa.shift_count), 32'd7);
        check("dir_wv_low", 32'(ifa.word_valid), 32'h0);
        check("dir_out_r", 32'(ifa.out), 32'h00);
        step();
        check("dir_wv", 32'(ifa.word_valid), 32'h1);
        check("dir_cnt0", 32'(ifa.shift_count), 32'h0);
        ifa.en = 1'b0;
        step();
        check("dir_wv_drop", 32'(ifa.word_valid), 32'h0);

`ifdef USR_ROTATE_EN
        ifa.en = 1'b1; ifa.mode = 2'd3; ifa.load_data = 8'h81;
        step();
        ifa.mode = 2'd1; ifa.rotate = 1'b1; ifa.in = 1'b0;
        step();
        ifa.en = 1'b0; ifa.rotate = 1'b0;
        check("rot_out", 32'(ifa.out), 32'h03);
        check("rot_cnt", 32'(ifa.shift_count), 32'd1);
`endif

        // Two 4-bit lanes with different serial inputs.
        ifb.en = 1'b1; ifb.mode = 2'd1; ifb.in = 2'b10;
        for (int i = 0; i < 3; i++) step();
        check("b_wv_low", 32'(ifb.word_valid), 32'h0);
        check("b_cnt3", 32'(ifb.shift_count), 32'd3);
        step();
        ifb.en = 1'b0;
        check("b_out", 32'(ifb.out), 32'hF0);
        check("b_wv", 32'(ifb.word_valid), 32'h1);
        check("b_cnt0", 32'(ifb.shift_count), 32'h0);
        step();
        check("b_wv_drop", 32'(ifb.word_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter: LANES, 1, number of independent shift lanes (>=1).
REQ-002 Parameter: DEPTH, 8, bits per lane (>=2).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk.
REQ-005 en  input  1  shift/load enable; when low all state holds.
REQ-006 mode  input  2  operation select: HOLD=0, SHIFT_LEFT=1, SHIFT_RIGHT=2, LOAD=3.
REQ-007 in  input  LANES  serial input bit per lane.
REQ-008 load_data  input  LANES*DEPTH  parallel load word; lane k occupies bits [k*DEPTH +: DEPTH].
REQ-009 out  output  LANES*DEPTH  registered parallel contents, same lane packing as load_data.
REQ-010 serial_out  output  LANES  bit leaving each lane on the current shift.
REQ-011 word_valid  output  1  one-cycle registered pulse marking completion of DEPTH shifts.
REQ-012 shift_count  output  $clog2(DEPTH+1)  shifts accumulated in the current word.

Function
REQ-013 SHIFT_LEFT with en=1 SHALL update each lane to {lane[DEPTH-2:0], in[k]} (serial bit enters LSB).
REQ-014 SHIFT_RIGHT with en=1 SHALL update each lane to {in[k], lane[DEPTH-1:1]} (serial bit enters MSB).
REQ-015 LOAD with en=1 SHALL copy load_data into out in one cycle and clear shift_count to 0.
REQ-016 HOLD, or en=0 in any mode, SHALL leave out and shift_count unchanged and drive word_valid low next cycle.
REQ-017 serial_out[k] SHALL be combinational: lane[DEPTH-1] when mode=SHIFT_LEFT, lane[0] when mode=SHIFT_RIGHT, 0 otherwise.
REQ-018 Each enabled shift SHALL increment shift_count; all lanes share one counter.
REQ-019 On the shift that brings shift_count to DEPTH, shift_count SHALL wrap to 0 and word_valid SHALL be high for exactly the following cycle.
REQ-020 Changing direction mid-word SHALL not reset shift_count; counting continues.
REQ-021 word_valid SHALL be low in every cycle not covered by REQ-019; back-to-back words give one pulse every DEPTH enabled shifts.
REQ-022 Latency: every register update visible on out one cycle after the sampling edge; no combinational path from in to out.

Reset
REQ-023 reset SHALL take priority over en, mode and LOAD.
REQ-024 On a reset edge out, shift_count and word_valid SHALL become 0, including mid-word and during an active word_valid pulse.
REQ-025 The first enabled shift after reset deassertion SHALL be counted as shift 1.

Configuration
REQ-026 With USR_ROTATE_EN defined, a 1-bit input rotate SHALL exist; when high during a shift the bit entering each lane SHALL be that lane's serial_out bit instead of in[k].
REQ-027 Without USR_ROTATE_EN, the rotate port SHALL be absent and shifts SHALL always take in[k].
REQ-028 Rotation SHALL count toward shift_count and word_valid like any shift.

Structure
REQ-029 Package usr_pkg SHALL hold the usr_mode_e typedef (HOLD, SHIFT_LEFT, SHIFT_RIGHT, LOAD) and its 2-bit encodings.
REQ-030 Sub-module usr_lane SHALL implement one DEPTH-bit lane (shift/load/serial_out), generated LANES times; shift_count and word_valid live in the top.

Verification
REQ-031 Reset asserted 1 cycle -> out=0, shift_count=0, word_valid=0, serial_out=0.
REQ-032 LANES=1, DEPTH=8, SHIFT_LEFT, in=1 for 1 cycle then 0 for 7 -> out 0x01,0x02,...,0x80; word_valid high exactly in the cycle after the 8th shift edge; shift_count back to 0.
REQ-033 LOAD 0xA5, then SHIFT_RIGHT in=0 for 4 cycles -> serial_out 1,0,1,0; out ends 0x0A; shift_count=4.
REQ-034 After 5 shifts, en=0 with mode=SHIFT_LEFT for 3 cycles, then reset with mode=LOAD -> out and shift_count frozen during hold; after reset out=0, count=0, load ignored.
REQ-035 LANES=2, DEPTH=4, SHIFT_LEFT, in=2'b10 for 4 cycles -> out=8'hF0, one word_valid pulse.
REQ-036 USR_ROTATE_EN defined, LOAD 0x81, rotate=1, SHIFT_LEFT one cycle -> out=0x03, shift_count=1.
